// File: rtl/zx_port_fe_out.sv
// ULA port FE write side: latches border/EAR/MIC from OUT (FE),n, defers border to line start, makes 50 Hz int_n.
// Latency 1 clk from accepted write, no backpressure (writes always taken); ZX_BEEPER_DAC_EN selects sigma-delta audio.
module zx_port_fe_out #(
  parameter bit         FULL_DECODE  = 1'b1,
  parameter int         FRAME_CYCLES = 69888,
  parameter int         INT_LEN      = 32,
  parameter logic [7:0] EAR_LEVEL    = 8'd200,
  parameter logic [7:0] MIC_LEVEL    = 8'd40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] ad,
  input  logic [7:0]  data_in,
  input  logic        t_en,
  input  logic        line_start,
  output logic [2:0]  border,
  output logic        ear,
  output logic        mic,
  output logic        audio_out,
  output logic        int_n,
  output logic        wr_strobe
);

  localparam int            CW      = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST    = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] INT_END = CW'(INT_LEN);

  logic          addr_match;
  logic          hit;
  logic          hit_q;
  logic          accept;
  logic [2:0]    pending;
  logic          pend_v;
  logic [CW-1:0] count;

  assign addr_match = FULL_DECODE ? (ad[7:0] == 8'hFE) : !ad[0];
  assign hit        = !ce && !wr_n && rd_n && addr_match;
  assign accept     = hit && !hit_q;

  // hit_q resets high so a write held across reset is not taken until the bus idles once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q     <= 1'b1;
      wr_strobe <= 1'b0;
      border    <= 3'd0;
      pending   <= 3'd0;
      pend_v    <= 1'b0;
      ear       <= 1'b0;
      mic       <= 1'b0;
      count     <= '0;
      int_n     <= 1'b1;
    end else begin
      hit_q     <= hit;
      wr_strobe <= accept;
      if (line_start && pend_v)
        border <= pending;
      // A write coinciding with line_start becomes pending for the following line.
      if (accept) begin
        pending <= data_in[2:0];
        pend_v  <= 1'b1;
        ear     <= data_in[4];
        mic     <= data_in[3];
      end else if (line_start) begin
        pend_v  <= 1'b0;
      end
      if (t_en)
        count <= (count == LAST) ? '0 : count + CW'(1);
      int_n <= !(count < INT_END);
    end
  end

`ifdef ZX_BEEPER_DAC_EN
  logic [8:0] acc;
  logic [8:0] level;
  logic [9:0] sum;
  logic       unused_bits;

  assign level       = (ear ? {1'b0, EAR_LEVEL} : 9'd0) + (mic ? {1'b0, MIC_LEVEL} : 9'd0);
  assign sum         = {1'b0, acc} + {1'b0, level};
  assign unused_bits = ^{ad[15:8], data_in[7:5]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= 9'd0;
      audio_out <= 1'b0;
    end else begin
      acc       <= sum[8:0];
      audio_out <= sum[9];
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{ad[15:8], data_in[7:5], mic, EAR_LEVEL, MIC_LEVEL};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      audio_out <= 1'b0;
    else
      audio_out <= ear;
  end
`endif

endmodule

// File: tb/tb_zx_port_fe_out.sv
// Directed bench for zx_port_fe_out: full-decode instance (dut0) and partial-decode instance (dut1) on one bus.
module tb_zx_port_fe_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce, rd_n, wr_n, t_en, line_start;
  logic [15:0] ad;
  logic [7:0]  data_in;

  logic [2:0]  border0, border1;
  logic        ear0, ear1, mic0, mic1, audio0, audio1, int_n0, int_n1, strobe0, strobe1;

  int checks   = 0;
  int failures = 0;
  int s0       = 0;
  int s1       = 0;

  always #5 clk = ~clk;

  zx_port_fe_out #(
    .FULL_DECODE(1'b1), .FRAME_CYCLES(100), .INT_LEN(32), .EAR_LEVEL(8'd128), .MIC_LEVEL(8'd40)
  ) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .rd_n(rd_n), .wr_n(wr_n), .ad(ad), .data_in(data_in),
    .t_en(t_en), .line_start(line_start), .border(border0), .ear(ear0), .mic(mic0),
    .audio_out(audio0), .int_n(int_n0), .wr_strobe(strobe0)
  );

  zx_port_fe_out #(
    .FULL_DECODE(1'b0), .FRAME_CYCLES(100), .INT_LEN(32), .EAR_LEVEL(8'd128), .MIC_LEVEL(8'd40)
  ) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .rd_n(rd_n), .wr_n(wr_n), .ad(ad), .data_in(data_in),
    .t_en(t_en), .line_start(line_start), .border(border1), .ear(ear1), .mic(mic1),
    .audio_out(audio1), .int_n(int_n1), .wr_strobe(strobe1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    s0 += int'(strobe0);
    s1 += int'(strobe1);
  endtask

  task automatic bus_idle();
    ce = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d, input int n);
    ad = a; data_in = d; ce = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
    repeat (n) cyc();
    bus_idle();
    cyc();
  endtask

  task automatic line_pulse();
    line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; t_en = 1'b1; line_start = 1'b0; ad = 16'h0000; data_in = 8'h00;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_border", 32'(border0), 32'd0);
    chk("rst_ear", 32'(ear0), 32'd0);
    chk("rst_mic", 32'(mic0), 32'd0);
    chk("rst_int_n", 32'(int_n0), 32'd1);
    chk("rst_strobe", 32'(strobe0), 32'd0);
    chk("rst_audio", 32'(audio0), 32'd0);
    reset = 1'b1;

    // T1: load state, then reset mid-frame while a write is held on the bus
    repeat (40) cyc();
    write(16'h00FE, 8'h1F, 1);
    line_pulse();
    chk("t1_border_pre", 32'(border0), 32'd7);
    ad = 16'h00FE; data_in = 8'h1F; ce = 1'b0; wr_n = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    chk("t1_border", 32'(border0), 32'd0);
    chk("t1_ear", 32'(ear0), 32'd0);
    chk("t1_mic", 32'(mic0), 32'd0);
    chk("t1_int_n", 32'(int_n0), 32'd1);
    cyc();
    reset = 1'b1;
    s0 = 0;
    repeat (3) cyc();
    chk("t1_held_write_ignored", 32'(s0), 32'd0);
    chk("t1_ear_after", 32'(ear0), 32'd0);
    bus_idle();
    cyc();

    // T4: clean reset, then int_n over two frames plus
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    for (int k = 1; k <= 210; k++) begin
      cyc();
      chk("t4_int_n", 32'(int_n0), 32'(((k - 1) % 100) >= 32));
    end

    // T2: held write accepted once, border deferred to line start
    s0 = 0;
    ad = 16'h00FE; data_in = 8'h15; ce = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
    cyc();
    chk("t2_strobe", 32'(strobe0), 32'd1);
    chk("t2_ear", 32'(ear0), 32'd1);
    chk("t2_mic", 32'(mic0), 32'd0);
`ifndef ZX_BEEPER_DAC_EN
    chk("t2_audio_lag", 32'(audio0), 32'd0);
`endif
    cyc();
    chk("t2_strobe_off", 32'(strobe0), 32'd0);
`ifndef ZX_BEEPER_DAC_EN
    chk("t2_audio", 32'(audio0), 32'd1);
`endif
    cyc();
    cyc();
    bus_idle();
    cyc();
    chk("t2_one_strobe", 32'(s0), 32'd1);
    chk("t2_border_deferred", 32'(border0), 32'd0);
    line_pulse();
    chk("t2_border", 32'(border0), 32'd5);

    // T3: write coinciding with line_start
    write(16'h00FE, 8'h06, 1);
    chk("t3_border_hold", 32'(border0), 32'd5);
    ad = 16'h00FE; data_in = 8'h02; ce = 1'b0; wr_n = 1'b0; line_start = 1'b1;
    cyc();
    line_start = 1'b0;
    chk("t3_old_pending", 32'(border0), 32'd6);
    cyc();
    bus_idle();
    cyc();
    line_pulse();
    chk("t3_new_pending", 32'(border0), 32'd2);
    line_pulse();
    chk("t3_no_pending", 32'(border0), 32'd2);

    // two writes in one line: last wins
    write(16'h00FE, 8'h01, 1);
    write(16'h00FE, 8'h04, 2);
    line_pulse();
    chk("last_write_wins", 32'(border0), 32'd4);

    // non-writes: rd+wr together, ce high, sub-clock ce glitch
    s0 = 0;
    ad = 16'h00FE; data_in = 8'hFF; ce = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    cyc();
    cyc();
    bus_idle();
    wr_n = 1'b0;
    cyc();
    cyc();
    #2 ce = 1'b0;
    #2 ce = 1'b1;
    cyc();
    bus_idle();
    cyc();
    chk("rejected_strobes", 32'(s0), 32'd0);
    chk("rejected_ear", 32'(ear0), 32'd0);
    line_pulse();
    chk("rejected_border", 32'(border0), 32'd4);

    write(16'h00FE, 8'hE3, 1);
    line_pulse();
    chk("high_bits_border", 32'(border0), 32'd3);
    chk("high_bits_ear", 32'(ear0), 32'd0);

    // T5: address decode, full vs partial
    s0 = 0; s1 = 0;
    write(16'h00FD, 8'h1A, 1);
    write(16'h12FF, 8'h1A, 1);
    chk("t5_full_odd", 32'(s0), 32'd0);
    chk("t5_part_odd", 32'(s1), 32'd0);
    write(16'h00FC, 8'h08, 1);
    chk("t5_full_fc", 32'(s0), 32'd0);
    chk("t5_part_fc", 32'(s1), 32'd1);
    chk("t5_part_mic", 32'(mic1), 32'd1);
    chk("t5_full_mic", 32'(mic0), 32'd0);

    // T6: audio path
`ifdef ZX_BEEPER_DAC_EN
    begin
      int ones;
      write(16'h00FE, 8'h10, 1);
      repeat (4) cyc();
      ones = 0;
      repeat (1024) begin
        cyc();
        ones += int'(audio0);
      end
      chk("t6_dac_density", 32'(ones), 32'd256);
    end
`else
    ad = 16'h00FE; data_in = 8'h10; ce = 1'b0; wr_n = 1'b0;
    cyc();
    chk("t6_ear_set", 32'(ear0), 32'd1);
    chk("t6_audio_lag", 32'(audio0), 32'd0);
    bus_idle();
    cyc();
    chk("t6_audio_rise", 32'(audio0), 32'd1);
    ad = 16'h00FE; data_in = 8'h08; ce = 1'b0; wr_n = 1'b0;
    cyc();
    chk("t6_audio_hold", 32'(audio0), 32'd1);
    bus_idle();
    cyc();
    chk("t6_audio_fall", 32'(audio0), 32'd0);
    cyc();
    chk("t6_mic_no_audio", 32'(audio0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
